// File: rtl/cus19_pkg.sv
// Shared definitions for the Custom-19 core: type codes, ALU funcs, jump sub-ops, field positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cus19_pkg;

    localparam int DATA_W = 8;

    // Instruction type field, instr[2:0]; 100-111 are the reserved crypto space and decode as NOP
    localparam logic [2:0] TYPE_ALU = 3'b000;
    localparam logic [2:0] TYPE_LS  = 3'b001;
    localparam logic [2:0] TYPE_JMP = 3'b010;
    localparam logic [2:0] TYPE_BR  = 3'b011;

    // ALU function codes, instr[6:3]; codes above FN_SHR are NOPs
    localparam logic [3:0] FN_NOP = 4'd0;
    localparam logic [3:0] FN_ADD = 4'd1;
    localparam logic [3:0] FN_MUL = 4'd2;
    localparam logic [3:0] FN_DIV = 4'd3;
    localparam logic [3:0] FN_SUB = 4'd4;
    localparam logic [3:0] FN_AND = 4'd5;
    localparam logic [3:0] FN_OR  = 4'd6;
    localparam logic [3:0] FN_XOR = 4'd7;
    localparam logic [3:0] FN_NOT = 4'd8;
    localparam logic [3:0] FN_SHL = 4'd9;
    localparam logic [3:0] FN_SHR = 4'd10;

    // Jump sub-operation, instr[4:3]
    typedef enum logic [1:0] {
        JOP_JMP  = 2'b00,
        JOP_CALL = 2'b01,
        JOP_RET  = 2'b10,
        JOP_HALT = 2'b11
    } jop_e;

    // Field LSB positions within the 19-bit word
    localparam int RD_LSB      = 15;  // ALU rd / load-store data register
    localparam int RS1_LSB     = 11;  // ALU rs1 / load-store base
    localparam int RS2_LSB     = 7;
    localparam int FUNC_LSB    = 3;
    localparam int LS_OFF_LSB  = 4;   // 7-bit offset
    localparam int LS_ST_BIT   = 3;
    localparam int JMP_TGT_LSB = 8;   // 11-bit target
    localparam int JMP_OP_LSB  = 3;
    localparam int BR_TGT_LSB  = 12;  // 7-bit target
    localparam int BR_RS1_LSB  = 8;
    localparam int BR_RS2_LSB  = 4;
    localparam int BR_NE_BIT   = 3;

    // True for funcs that write rd and update the ALU result output
    function automatic logic alu_func_valid(input logic [3:0] f);
        return (f != FN_NOP) && (f <= FN_SHR);
    endfunction

endpackage

// File: rtl/cus19_alu.sv
// Combinational 8-bit ALU producing a 16-bit result (wide for MUL, {rem,quo} for DIV).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module cus19_alu
    import cus19_pkg::*;
(
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [3:0]          func_i,
    output logic [2*DATA_W-1:0] result_o
);

    logic [DATA_W:0] sum9;

    assign sum9 = {1'b0, a_i} + {1'b0, b_i};

    // Result select; divide by zero yields quotient all-ones and remainder = dividend
    always_comb begin
        result_o = '0;
        case (func_i)
            FN_ADD: result_o = {{(DATA_W-1){1'b0}}, sum9};
            FN_MUL: result_o = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
            FN_DIV: begin
                if (b_i == '0) result_o = {a_i, {DATA_W{1'b1}}};
                else           result_o = {a_i % b_i, a_i / b_i};
            end
            FN_SUB: result_o = {{DATA_W{1'b0}}, a_i - b_i};
            FN_AND: result_o = {{DATA_W{1'b0}}, a_i & b_i};
            FN_OR:  result_o = {{DATA_W{1'b0}}, a_i | b_i};
            FN_XOR: result_o = {{DATA_W{1'b0}}, a_i ^ b_i};
            FN_NOT: result_o = {{DATA_W{1'b0}}, ~a_i};
            FN_SHL: result_o = {{DATA_W{1'b0}}, a_i << b_i[2:0]};
            FN_SHR: result_o = {{DATA_W{1'b0}}, a_i >> b_i[2:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/cus19_imem.sv
// Instruction memory with asynchronous read; contents are loaded by backdoor, zero at time 0.
// Latency: 0 cycles (combinational fetch).
// Backpressure: none.
module cus19_imem #(
    parameter int Addr_Width  = 11,
    parameter int Instr_Width = 19
) (
    input  logic [Addr_Width-1:0]  addr_i,
    output logic [Instr_Width-1:0] instr_o
);

    // All-zero word decodes as ALU NOP, so an unloaded memory simply runs NOPs
    logic [Instr_Width-1:0] mem [0:(2**Addr_Width)-1] = '{default: '0};

    assign instr_o = mem[addr_i];

endmodule

// File: rtl/cus19_regfile.sv
// Register file: three asynchronous read ports, one write port; no reset so preloads survive.
// Latency: reads 0 cycles, write visible after the rising edge.
// Backpressure: none.
module cus19_regfile #(
    parameter int Addr_Width = 4,
    parameter int Data_Width = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [Addr_Width-1:0] waddr_i,
    input  logic [Data_Width-1:0] wdata_i,
    input  logic [Addr_Width-1:0] raddr_a_i,
    input  logic [Addr_Width-1:0] raddr_b_i,
    input  logic [Addr_Width-1:0] raddr_c_i,
    output logic [Data_Width-1:0] rdata_a_o,
    output logic [Data_Width-1:0] rdata_b_o,
    output logic [Data_Width-1:0] rdata_c_o
);

    logic [Data_Width-1:0] reg_file [0:(2**Addr_Width)-1];

    // Single write port; R0 is an ordinary register
    always @(posedge clk_i) begin
        if (we_i) reg_file[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = reg_file[raddr_a_i];
    assign rdata_b_o = reg_file[raddr_b_i];
    assign rdata_c_o = reg_file[raddr_c_i];

endmodule

// File: rtl/cus19_top.sv
// Custom-19 single-cycle core: fetch, decode, execute and write back in one clock.
// Latency: one instruction per cycle; outputs registered at the executing edge.
// Backpressure: none; HALT freezes the PC until reset.
module cus19_top
    import cus19_pkg::*;
#(
    parameter int PC_Width       = 11,
    parameter int Stack_Depth    = 8,
    parameter int Instr_Width    = 19,
    parameter int Data_Width     = 8,
    parameter int Reg_Addr_Width = 4
) (
    input  logic                    cus19_clk_in,
    input  logic                    cus19_rst_in,
    output logic [2*Data_Width-1:0] alu_result_out,
    output logic [2*Data_Width-1:0] ld_result_out
);

    localparam int SP_W  = $clog2(Stack_Depth + 1);
    localparam int IDX_W = $clog2(Stack_Depth);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(Stack_Depth);

    logic [PC_Width-1:0]     pc_q, pc_d, pc_inc;
    logic [SP_W-1:0]         sp_q, sp_d, sp_dec;
    logic                    halt_q, halt_d;
    logic [2*Data_Width-1:0] alu_res_q, alu_res_d, ld_res_q, ld_res_d;
    logic [PC_Width-1:0]     stack_q [0:Stack_Depth-1];
    logic [Data_Width-1:0]   dmem_q [0:(2**Data_Width)-1] = '{default: '0};

    logic [Instr_Width-1:0]    instr;
    logic [2:0]                typ;
    logic [Reg_Addr_Width-1:0] ra_idx, rb_idx, rd_idx;
    logic [Data_Width-1:0]     ra_dat, rb_dat, rc_dat;
    logic [2*Data_Width-1:0]   alu_res;
    logic [Data_Width-1:0]     ls_addr, dm_rdat;
    logic                      rf_we, dm_we, push;
    logic [Data_Width-1:0]     rf_wdat;

    cus19_imem #(.Addr_Width(PC_Width), .Instr_Width(Instr_Width)) M2 (
        .addr_i  (pc_q),
        .instr_o (instr)
    );

    assign typ    = instr[2:0];
    assign rd_idx = instr[RD_LSB +: 4];
    // Branches place their source registers lower in the word than ALU/load-store
    assign ra_idx = (typ == TYPE_BR) ? instr[BR_RS1_LSB +: 4] : instr[RS1_LSB +: 4];
    assign rb_idx = (typ == TYPE_BR) ? instr[BR_RS2_LSB +: 4] : instr[RS2_LSB +: 4];

    cus19_regfile #(.Addr_Width(Reg_Addr_Width), .Data_Width(Data_Width)) M5 (
        .clk_i     (cus19_clk_in),
        .we_i      (rf_we & ~cus19_rst_in),
        .waddr_i   (rd_idx),
        .wdata_i   (rf_wdat),
        .raddr_a_i (ra_idx),
        .raddr_b_i (rb_idx),
        .raddr_c_i (rd_idx),
        .rdata_a_o (ra_dat),
        .rdata_b_o (rb_dat),
        .rdata_c_o (rc_dat)
    );

    cus19_alu u_alu (
        .a_i      (ra_dat),
        .b_i      (rb_dat),
        .func_i   (instr[FUNC_LSB +: 4]),
        .result_o (alu_res)
    );

    assign ls_addr = ra_dat + {{(Data_Width-7){1'b0}}, instr[LS_OFF_LSB +: 7]};
    assign dm_rdat = dmem_q[ls_addr];
    assign pc_inc  = pc_q + 1'b1;
    assign sp_dec  = sp_q - 1'b1;

    // Decode/execute: next PC, stack pointer, halt flag, write enables and output updates
    always_comb begin
        pc_d      = pc_inc;
        sp_d      = sp_q;
        halt_d    = halt_q;
        alu_res_d = alu_res_q;
        ld_res_d  = ld_res_q;
        rf_we     = 1'b0;
        rf_wdat   = '0;
        dm_we     = 1'b0;
        push      = 1'b0;
        if (halt_q) begin
            pc_d = pc_q;
        end else begin
            case (typ)
                TYPE_ALU: begin
                    if (alu_func_valid(instr[FUNC_LSB +: 4])) begin
                        rf_we     = 1'b1;
                        rf_wdat   = alu_res[Data_Width-1:0];
                        alu_res_d = alu_res;
                    end
                end
                TYPE_LS: begin
                    if (instr[LS_ST_BIT]) begin
                        dm_we = 1'b1;
                    end else begin
                        rf_we    = 1'b1;
                        rf_wdat  = dm_rdat;
                        ld_res_d = {{Data_Width{1'b0}}, dm_rdat};
                    end
                end
                TYPE_JMP: begin
                    case (instr[JMP_OP_LSB +: 2])
                        JOP_JMP: pc_d = instr[JMP_TGT_LSB +: PC_Width];
                        JOP_CALL: begin
                            // A full stack still jumps; only the return address is lost
                            pc_d = instr[JMP_TGT_LSB +: PC_Width];
                            if (sp_q != SP_FULL) begin
                                push = 1'b1;
                                sp_d = sp_q + 1'b1;
                            end
                        end
                        JOP_RET: begin
                            // Empty stack falls through to PC+1
                            if (sp_q != '0) begin
                                pc_d = stack_q[sp_dec[IDX_W-1:0]];
                                sp_d = sp_dec;
                            end
                        end
                        default: begin
                            pc_d   = pc_q;
                            halt_d = 1'b1;
                        end
                    endcase
                end
                TYPE_BR: begin
                    if (instr[BR_NE_BIT] ? (ra_dat != rb_dat) : (ra_dat == rb_dat)) begin
                        pc_d = {{(PC_Width-7){1'b0}}, instr[BR_TGT_LSB +: 7]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural state with synchronous reset; reset overrides the instruction in flight
    always_ff @(posedge cus19_clk_in) begin
        if (cus19_rst_in) begin
            pc_q      <= '0;
            sp_q      <= '0;
            halt_q    <= 1'b0;
            alu_res_q <= '0;
            ld_res_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            halt_q    <= halt_d;
            alu_res_q <= alu_res_d;
            ld_res_q  <= ld_res_d;
        end
    end

    // Return stack and data memory writes; contents are not cleared by reset
    always_ff @(posedge cus19_clk_in) begin
        if (!cus19_rst_in && push)  stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
        if (!cus19_rst_in && dm_we) dmem_q[ls_addr] <= rc_dat;
    end

    assign alu_result_out = alu_res_q;
    assign ld_result_out  = ld_res_q;

endmodule

// File: tb/tb_cus19_top.sv
module tb_cus19_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] alu_o, ld_o;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    cus19_top dut (
        .cus19_clk_in   (clk),
        .cus19_rst_in   (rst),
        .alu_result_out (alu_o),
        .ld_result_out  (ld_o)
    );

    localparam logic [3:0] F_NOP = 4'd0, F_ADD = 4'd1, F_MUL = 4'd2, F_DIV = 4'd3,
                           F_SUB = 4'd4, F_AND = 4'd5, F_OR = 4'd6, F_XOR = 4'd7,
                           F_NOT = 4'd8, F_SHL = 4'd9, F_SHR = 4'd10;
    localparam logic [1:0] J_JMP = 2'd0, J_CALL = 2'd1, J_RET = 2'd2, J_HALT = 2'd3;

    typedef struct {
        logic [3:0]  func;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_alu;
        logic [7:0]  exp_rd;
    } vec_t;

    function automatic logic [18:0] enc_alu(input logic [3:0] rd, input logic [3:0] rs1,
                                            input logic [3:0] rs2, input logic [3:0] fn);
        return {rd, rs1, rs2, fn, 3'b000};
    endfunction
    function automatic logic [18:0] enc_ls(input logic [3:0] r, input logic [3:0] base,
                                           input logic [6:0] off, input logic st);
        return {r, base, off, st, 3'b001};
    endfunction
    function automatic logic [18:0] enc_jmp(input logic [10:0] tgt, input logic [1:0] op);
        return {tgt, 3'b000, op, 3'b010};
    endfunction
    function automatic logic [18:0] enc_br(input logic [6:0] tgt, input logic [3:0] rs1,
                                           input logic [3:0] rs2, input logic ne);
        return {tgt, rs1, rs2, ne, 3'b011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Apply reset for one edge, then clear instruction memory while reset is still held
    task automatic hold_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2048; i++) dut.M2.mem[i] = '0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rf(input int r);
        return dut.M5.reg_file[r];
    endfunction

    // Reference model state for the random program
    int m_reg [16];
    int m_mem [256];
    int m_alu, m_ld;

    initial begin
        vec_t tbl [14];
        logic [18:0] prog [200];
        logic [3:0]  f_rd [200], f_rs1 [200], f_rs2 [200], f_fn [200];
        logic [6:0]  f_off [200];
        logic        f_st [200], f_ls [200];

        tbl[0]  = '{F_ADD, 8'd200, 8'd100, 16'h012C, 8'h2C};
        tbl[1]  = '{F_ADD, 8'hFF,  8'hFF,  16'h01FE, 8'hFE};
        tbl[2]  = '{F_SUB, 8'd5,   8'd10,  16'h00FB, 8'hFB};
        tbl[3]  = '{F_MUL, 8'd200, 8'd200, 16'h9C40, 8'h40};
        tbl[4]  = '{F_DIV, 8'd7,   8'd0,   16'h07FF, 8'hFF};
        tbl[5]  = '{F_DIV, 8'd100, 8'd7,   16'h020E, 8'h0E};
        tbl[6]  = '{F_AND, 8'hF0,  8'h3C,  16'h0030, 8'h30};
        tbl[7]  = '{F_OR,  8'hF0,  8'h3C,  16'h00FC, 8'hFC};
        tbl[8]  = '{F_XOR, 8'hF0,  8'h3C,  16'h00CC, 8'hCC};
        tbl[9]  = '{F_NOT, 8'hF0,  8'h3C,  16'h000F, 8'h0F};
        tbl[10] = '{F_SHL, 8'h81,  8'h0B,  16'h0008, 8'h08};
        tbl[11] = '{F_SHR, 8'h81,  8'h0B,  16'h0010, 8'h10};
        tbl[12] = '{F_NOP, 8'h12,  8'h34,  16'h0000, 8'h5A};
        tbl[13] = '{4'd15, 8'h12,  8'h34,  16'h0000, 8'h5A};

        // ---- Random straight-line program of ALU and load/store ops against a model ----
        // Data memory is still all zero here, so the model starts from zeros too.
        hold_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        m_alu = 0;
        m_ld  = 0;
        for (int r = 0; r < 16; r++) begin
            m_reg[r] = $urandom_range(0, 255);
            dut.M5.reg_file[r] = 8'(m_reg[r]);
        end
        for (int k = 0; k < 200; k++) begin
            f_rd[k]  = 4'($urandom);
            f_rs1[k] = 4'($urandom);
            f_rs2[k] = 4'($urandom);
            f_fn[k]  = 4'($urandom);
            f_off[k] = 7'($urandom);
            f_st[k]  = 1'($urandom);
            f_ls[k]  = ($urandom_range(0, 2) == 0);
            prog[k]  = f_ls[k] ? enc_ls(f_rd[k], f_rs1[k], f_off[k], f_st[k])
                               : enc_alu(f_rd[k], f_rs1[k], f_rs2[k], f_fn[k]);
            dut.M2.mem[k] = prog[k];
        end
        release_rst();
        for (int k = 0; k < 200; k++) begin
            int a, b, r, addr, sh;
            bit ok;
            if (f_ls[k]) begin
                addr = (m_reg[f_rs1[k]] + int'(f_off[k])) % 256;
                if (f_st[k]) begin
                    m_mem[addr] = m_reg[f_rd[k]];
                end else begin
                    m_reg[f_rd[k]] = m_mem[addr];
                    m_ld = m_mem[addr];
                end
            end else begin
                a  = m_reg[f_rs1[k]];
                b  = m_reg[f_rs2[k]];
                sh = 1 << (b % 8);
                ok = 1'b1;
                r  = 0;
                case (f_fn[k])
                    F_ADD: r = a + b;
                    F_MUL: r = a * b;
                    F_DIV: r = (b == 0) ? a * 256 + 255 : (a % b) * 256 + a / b;
                    F_SUB: r = (a - b + 256) % 256;
                    F_AND: r = a & b;
                    F_OR:  r = a | b;
                    F_XOR: r = a ^ b;
                    F_NOT: r = 255 - a;
                    F_SHL: r = (a * sh) % 256;
                    F_SHR: r = a / sh;
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    m_reg[f_rd[k]] = r % 256;
                    m_alu = r;
                end
            end
            step(1);
            chk($sformatf("rand%0d alu", k), 32'(alu_o), 32'(m_alu));
            chk($sformatf("rand%0d ld", k), 32'(ld_o), 32'(m_ld));
        end
        for (int r = 0; r < 16; r++) chk($sformatf("rand R%0d", r), 32'(rf(r)), 32'(m_reg[r]));

        // ---- Reset state: outputs and PC cleared, registers kept ----
        hold_reset();
        chk("reset pc", 32'(dut.pc_q), 0);
        chk("reset alu", 32'(alu_o), 0);
        chk("reset ld", 32'(ld_o), 0);
        chk("reset keeps regs", 32'(rf(5)), 32'(m_reg[5]));

        // ---- Table of single ALU operations: R3 = R1 op R2 ----
        for (int t = 0; t < 14; t++) begin
            hold_reset();
            dut.M5.reg_file[1] = tbl[t].a;
            dut.M5.reg_file[2] = tbl[t].b;
            dut.M5.reg_file[3] = 8'h5A;
            dut.M2.mem[0] = enc_alu(4'd3, 4'd1, 4'd2, tbl[t].func);
            release_rst();
            step(1);
            chk($sformatf("tbl%0d alu", t), 32'(alu_o), 32'(tbl[t].exp_alu));
            chk($sformatf("tbl%0d rd", t), 32'(rf(3)), 32'(tbl[t].exp_rd));
        end

        // ---- Branch/ALU program ----
        hold_reset();
        dut.M5.reg_file[2] = 8'd5;
        dut.M5.reg_file[3] = 8'd5;
        dut.M5.reg_file[4] = 8'd10;
        dut.M2.mem[0]  = enc_br(7'd5, 4'd2, 4'd3, 1'b0);
        dut.M2.mem[5]  = enc_alu(4'd10, 4'd3, 4'd4, F_MUL);
        dut.M2.mem[6]  = enc_br(7'd10, 4'd3, 4'd4, 1'b1);
        dut.M2.mem[10] = enc_alu(4'd13, 4'd4, 4'd3, F_DIV);
        release_rst();
        step(1);
        chk("beq taken pc", 32'(dut.pc_q), 5);
        step(1);
        chk("mul alu", 32'(alu_o), 32'h0032);
        step(1);
        chk("bne taken pc", 32'(dut.pc_q), 10);
        step(1);
        chk("prog R10", 32'(rf(10)), 50);
        chk("prog R13", 32'(rf(13)), 2);
        chk("div alu", 32'(alu_o), 32'h0002);

        // ---- Not-taken branch ----
        hold_reset();
        dut.M5.reg_file[2] = 8'd5;
        dut.M5.reg_file[3] = 8'd6;
        dut.M2.mem[0] = enc_br(7'd5, 4'd2, 4'd3, 1'b0);
        release_rst();
        step(1);
        chk("beq not taken pc", 32'(dut.pc_q), 1);
        chk("beq R2", 32'(rf(2)), 5);
        chk("beq R3", 32'(rf(3)), 6);

        // ---- Store/load with address wrap ----
        hold_reset();
        dut.M5.reg_file[1] = 8'hF0;
        dut.M5.reg_file[5] = 8'hAB;
        dut.M5.reg_file[6] = 8'h00;
        dut.M2.mem[0] = enc_ls(4'd5, 4'd1, 7'd16, 1'b1);
        dut.M2.mem[1] = enc_ls(4'd6, 4'd1, 7'd16, 1'b0);
        release_rst();
        step(1);
        chk("store leaves ld", 32'(ld_o), 0);
        step(1);
        chk("load R6", 32'(rf(6)), 32'hAB);
        chk("load ld", 32'(ld_o), 32'h00AB);
        chk("load leaves alu", 32'(alu_o), 0);

        // ---- CALL / RET ----
        hold_reset();
        dut.M2.mem[3]   = enc_jmp(11'd100, J_CALL);
        dut.M2.mem[100] = enc_jmp(11'd0, J_RET);
        release_rst();
        step(4);
        chk("call pc", 32'(dut.pc_q), 100);
        step(1);
        chk("ret pc", 32'(dut.pc_q), 4);

        // ---- Nine nested CALLs: the ninth return address is dropped ----
        hold_reset();
        for (int i = 0; i < 9; i++) dut.M2.mem[10 * i] = enc_jmp(11'(10 * (i + 1)), J_CALL);
        dut.M2.mem[90] = enc_jmp(11'd0, J_RET);
        dut.M2.mem[71] = enc_jmp(11'd0, J_RET);
        release_rst();
        step(9);
        chk("nine calls pc", 32'(dut.pc_q), 90);
        chk("nine calls sp", 32'(dut.sp_q), 8);
        step(1);
        chk("ret after overflow", 32'(dut.pc_q), 71);
        step(1);
        chk("second ret", 32'(dut.pc_q), 61);

        // ---- RET on empty stack ----
        hold_reset();
        dut.M2.mem[0] = enc_jmp(11'd0, J_RET);
        release_rst();
        step(1);
        chk("empty ret pc", 32'(dut.pc_q), 1);
        chk("empty ret sp", 32'(dut.sp_q), 0);

        // ---- PC wrap 2047 -> 0 ----
        hold_reset();
        dut.M2.mem[0] = enc_jmp(11'd2047, J_JMP);
        release_rst();
        step(1);
        chk("jmp 2047", 32'(dut.pc_q), 2047);
        step(1);
        chk("pc wrap", 32'(dut.pc_q), 0);

        // ---- Reset mid-run overrides the load in flight; then HALT ----
        hold_reset();
        dut.M5.reg_file[0] = 8'h00;
        dut.M5.reg_file[1] = 8'd3;
        dut.M5.reg_file[2] = 8'd4;
        dut.M5.reg_file[8] = 8'h11;
        dut.M2.mem[0] = enc_alu(4'd7, 4'd1, 4'd2, F_ADD);
        dut.M2.mem[1] = enc_ls(4'd8, 4'd0, 7'd0, 1'b0);
        dut.M2.mem[2] = enc_jmp(11'd0, J_HALT);
        release_rst();
        step(1);
        chk("pre-reset alu", 32'(alu_o), 7);
        rst = 1'b1;
        step(1);
        chk("mid reset pc", 32'(dut.pc_q), 0);
        chk("mid reset alu", 32'(alu_o), 0);
        chk("mid reset ld", 32'(ld_o), 0);
        chk("mid reset R8 untouched", 32'(rf(8)), 32'h11);
        chk("mid reset R7 kept", 32'(rf(7)), 7);
        release_rst();
        step(6);
        chk("halt pc", 32'(dut.pc_q), 2);
        chk("halt ld", 32'(ld_o), 32'h00AB);
        chk("halt R8", 32'(rf(8)), 32'hAB);
        step(3);
        chk("halt holds pc", 32'(dut.pc_q), 2);
        rst = 1'b1;
        step(1);
        chk("halt reset pc", 32'(dut.pc_q), 0);
        release_rst();
        step(1);
        chk("after halt runs", 32'(dut.pc_q), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
